// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of the serialiser.
// Latency: a byte pushed into an empty idle block drives its start bit from the next edge.
// Backpressure: tx_ready drops while the FIFO is full; refused pushes set a sticky overflow.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   tx_valid        a byte is presented on tx_data_in
//   tx_data_in      byte to transmit
//   tx_ready        FIFO not full (push = tx_valid & tx_ready)
//   tx_data_out     serial line, idles high; 1 start, 8 data LSB first, 1 stop
//   tx_busy         a frame is on the line
//   tx_done         one-cycle pulse as a stop bit completes
//   fifo_count      bytes waiting in the FIFO (excludes the byte being shifted)
//   overflow        sticky: a push was attempted while tx_ready was low
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [7:0]        tx_data_in,
  output logic              tx_ready,
  output logic              tx_data_out,
  output logic              tx_busy,
  output logic              tx_done,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     clk_cnt, clk_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              line_nxt, done_nxt;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop, has_data, bit_last;

  assign tx_ready = (fifo_count != FULL_CNT);
  assign push     = tx_valid && tx_ready;
  assign has_data = (fifo_count != '0);
  assign bit_last = (clk_cnt == CNT_LAST);
  assign tx_busy  = (state != IDLE);

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (tx_valid && !tx_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      tx_data_out <= 1'b1;
      tx_done     <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift       <= shift_nxt;
      tx_data_out <= line_nxt;
      tx_done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    line_nxt    = tx_data_out;
    done_nxt    = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        line_nxt = 1'b1;
        if (has_data) begin
          pop         = 1'b1;
          shift_nxt   = mem[rd_ptr];
          state_nxt   = START;
          line_nxt    = 1'b0;
          clk_cnt_nxt = '0;
        end
      end
      START: begin
        if (bit_last) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
          line_nxt    = shift[0];
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          clk_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            line_nxt  = 1'b1;
          end else begin
            // Next bit is shift[1], which becomes shift[0] after this edge.
            shift_nxt   = shift >> 1;
            line_nxt    = shift[1];
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          done_nxt    = 1'b1;
          clk_cnt_nxt = '0;
          if (has_data) begin
            // Chain straight into the next start bit: no idle gap.
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
            line_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
            line_nxt  = 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        line_nxt  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int CPB   = 3;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data_in;
  logic       tx_ready, tx_data_out, tx_busy, tx_done, overflow;
  logic [2:0] fifo_count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data_in(tx_data_in),
    .tx_ready(tx_ready), .tx_data_out(tx_data_out), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;      // rising edges seen so far
  int base = 0;     // first byte index that survived the last reset
  int done_cnt = 0;
  int peak = 0;
  bit movf = 1'b0;

  // Reference timeline: each accepted byte gets a push edge and a frame start edge.
  int         q_push[$];
  int         q_start[$];
  logic [7:0] q_dat[$];

  function automatic int m_count(int t);
    int c = 0;
    for (int i = base; i < q_push.size(); i++)
      if (q_push[i] <= t && q_start[i] > t) c++;
    return c;
  endfunction

  task automatic model_at(input int t, output logic line, output logic busy, output logic done);
    logic [7:0] b;
    int k;
    line = 1'b1; busy = 1'b0; done = 1'b0;
    for (int i = base; i < q_start.size(); i++) begin
      if (q_start[i] + FRAME == t) done = 1'b1;
      if (t >= q_start[i] && t < q_start[i] + FRAME) begin
        busy = 1'b1;
        k = (t - q_start[i]) / CPB;
        b = q_dat[i];
        if (k == 0)      line = 1'b0;
        else if (k <= 8) line = b[k-1];
        else             line = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    logic el, eb, ed;
    int ec;
    model_at(cyc, el, eb, ed);
    ec = m_count(cyc);
    check("line",  {7'b0, tx_data_out}, {7'b0, el});
    check("busy",  {7'b0, tx_busy},     {7'b0, eb});
    check("done",  {7'b0, tx_done},     {7'b0, ed});
    check("count", {5'b0, fifo_count},  8'(ec));
    check("ready", {7'b0, tx_ready},    {7'b0, (ec != DEPTH)});
    check("ovf",   {7'b0, overflow},    {7'b0, movf});
    if (tx_done === 1'b1) done_cnt++;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  // Inputs change only at the falling edge; outputs are checked there too.
  task automatic step(input logic v, input logic [7:0] d, output bit acc);
    int s;
    bit rdy;
    tx_valid = v;
    tx_data_in = d;
    rdy = (m_count(cyc) != DEPTH);
    acc = v && rdy;
    @(posedge clk);
    cyc++;
    if (acc) begin
      s = cyc + 1;
      if (q_start.size() > base && q_start[q_start.size()-1] + FRAME > s)
        s = q_start[q_start.size()-1] + FRAME;
      q_push.push_back(cyc);
      q_start.push_back(s);
      q_dat.push_back(d);
    end
    if (v && !rdy) movf = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk);
    cyc++;
    base = q_push.size();
    movf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, a);
  endtask

  task automatic drain();
    bit a;
    int guard = 0;
    while (q_start.size() > base && cyc <= q_start[q_start.size()-1] + FRAME && guard < 5000) begin
      step(1'b0, 8'h00, a);
      guard++;
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    bit a;
    int s0, guard;
    logic [7:0] v;

    rst = 1'b1; tx_valid = 1'b0; tx_data_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Single byte
    done_cnt = 0;
    step(1'b1, 8'hA5, a);
    drain();
    idle(3);
    check("a5_dones", 8'(done_cnt), 8'd1);

    // Burst of four back-to-back
    done_cnt = 0; peak = 0;
    step(1'b1, 8'h00, a); step(1'b1, 8'hFF, a);
    step(1'b1, 8'h3C, a); step(1'b1, 8'h81, a);
    drain();
    check("burst_peak", 8'(peak), 8'd3);
    check("burst_dones", 8'(done_cnt), 8'd4);

    // Overflow: six pushes, sixth refused
    done_cnt = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), a);
    check("ovf_set", {7'b0, overflow}, 8'd1);
    drain();
    idle(5);
    check("ovf_sticky", {7'b0, overflow}, 8'd1);
    check("ovf_dones", 8'(done_cnt), 8'd5);
    do_reset();

    // Reset during data bit 3 with two bytes queued
    step(1'b1, 8'h55, a);
    s0 = q_start[q_start.size()-1];
    step(1'b1, 8'h66, a);
    step(1'b1, 8'h77, a);
    guard = 0;
    while (cyc < s0 + 12 && guard < 100) begin step(1'b0, 8'h00, a); guard++; end
    do_reset();
    check("rst_count", {5'b0, fifo_count}, 8'd0);
    done_cnt = 0;
    idle(40);
    check("rst_nodone", 8'(done_cnt), 8'd0);
    step(1'b1, 8'hC3, a);
    drain();
    check("c3_done", 8'(done_cnt), 8'd1);

    // Pointer wrap: 3 bytes, drain, then 4 more
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), a);
    drain();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), a);
    drain();

    // All 256 byte values as fast as tx_ready allows
    done_cnt = 0;
    for (int b = 0; b < 256; b++) begin
      guard = 0;
      a = 1'b0;
      while (!a && guard < 200) begin step(1'b1, 8'(b), a); guard++; end
      if (!a) check("push_timeout", 8'd0, 8'd1);
    end
    drain();
    check("all_dones", 16'(done_cnt) == 16'd256 ? 8'd1 : 8'd0, 8'd1);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else begin
        v = 8'($urandom);
        step(($urandom_range(0, 3) == 0), v, a);
      end
    end
    drain();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
